// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the WB stage and the mult/div unit (MC),
// with per-requester FIFOs, WB priority and an MC starvation guard. Macro RFARB_FWD_EN adds commit forwarding ports.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_sel,
    input  logic [31:0] wb_dat,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_sel,
    input  logic [31:0] mc_dat,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic [31:0] pending
`ifdef RFARB_FWD_EN
    ,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_dat,
    output logic [31:0] fwd2_dat
`endif
);
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW     = $clog2(STARVE_LIMIT + 1);
    localparam int REQ_WB = 0;
    localparam int REQ_MC = 1;

    logic [1:0]            push, pop, full, empty;
    logic [AW-1:0]         wr_ptr_q [2];
    logic [AW-1:0]         rd_ptr_q [2];
    logic [AW:0]           cnt_q    [2];
    logic [FIFO_DEPTH-1:0] vld_q    [2];
    logic [FIFO_DEPTH-1:0] vld_d    [2];
    logic [4:0]            sel_mem_q [2][FIFO_DEPTH];
    logic [31:0]           dat_mem_q [2][FIFO_DEPTH];
    logic [4:0]            head_sel [2];
    logic [31:0]           head_dat [2];

    logic                  force_mc, grant_mc, grant_wb;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  wen_q, wen_d;
    logic [4:0]            wsel_q, wsel_d;
    logic [31:0]           wdat_q, wdat_d;

    // Ready depends only on occupancy, so a pop in the same cycle never opens a full FIFO.
    assign wb_ready = !RST && !full[REQ_WB];
    assign mc_ready = !RST && !full[REQ_MC];
    assign push     = {mc_valid && mc_ready, wb_valid && wb_ready};
    assign pop      = {grant_mc, grant_wb};

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            full[r]     = (cnt_q[r] == (AW+1)'(FIFO_DEPTH));
            empty[r]    = (cnt_q[r] == '0);
            head_sel[r] = sel_mem_q[r][rd_ptr_q[r]];
            head_dat[r] = dat_mem_q[r][rd_ptr_q[r]];
            vld_d[r]    = vld_q[r];
            if (pop[r])  vld_d[r][rd_ptr_q[r]] = 1'b0;
            if (push[r]) vld_d[r][wr_ptr_q[r]] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int r = 0; r < 2; r++) begin
            if (RST) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
                vld_q[r]    <= '0;
            end else begin
                vld_q[r] <= vld_d[r];
                if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + 1'b1;
                if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + 1'b1;
                if (push[r] && !pop[r])      cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (pop[r] && !push[r]) cnt_q[r] <= cnt_q[r] - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; vld_q alone marks which slots hold live writes.
    always_ff @(posedge CLK) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                sel_mem_q[r][wr_ptr_q[r]] <= (r == REQ_WB) ? wb_sel : mc_sel;
                dat_mem_q[r][wr_ptr_q[r]] <= (r == REQ_WB) ? wb_dat : mc_dat;
            end
        end
    end

    always_comb begin
        force_mc = (starve_q == SW'(STARVE_LIMIT)) && !empty[REQ_MC];
        grant_mc = !empty[REQ_MC] && (force_mc || empty[REQ_WB]);
        grant_wb = !empty[REQ_WB] && !grant_mc;

        starve_d = starve_q;
        if (empty[REQ_MC] || grant_mc)         starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;

        // Register 0 writes are consumed but never raise the write enable.
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        if (grant_mc) begin
            wen_d  = (head_sel[REQ_MC] != '0);
            wsel_d = head_sel[REQ_MC];
            wdat_d = head_dat[REQ_MC];
        end else if (grant_wb) begin
            wen_d  = (head_sel[REQ_WB] != '0);
            wsel_d = head_sel[REQ_WB];
            wdat_d = head_dat[REQ_WB];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            wsel_q   <= '0;
            wdat_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            wsel_q   <= wsel_d;
            wdat_q   <= wdat_d;
        end
    end

    assign WEN  = wen_q;
    assign wsel = wsel_q;
    assign wdat = wdat_q;

    always_comb begin
        pending = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (vld_q[r][i]) pending[sel_mem_q[r][i]] = 1'b1;
            end
        end
        if (wen_q) pending[wsel_q] = 1'b1;
        pending[0] = 1'b0;
    end

`ifdef RFARB_FWD_EN
    assign fwd1_hit = wen_q && (wsel_q == rsel1) && (rsel1 != '0);
    assign fwd2_hit = wen_q && (wsel_q == rsel2) && (rsel2 != '0);
    assign fwd1_dat = fwd1_hit ? wdat_q : '0;
    assign fwd2_dat = fwd2_hit ? wdat_q : '0;
`endif

endmodule
